// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle unsigned multiply/divide unit beside EXE.
// One radix-2 iteration per clock (shift-add multiply, restoring divide).
// The pipeline is frozen while the unit works. The selected result is then
// presented for a single DONE cycle, and the freeze is released in that cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 32,  // operand/result width
  parameter int CNT_W = 6    // iteration counter width, 2**CNT_W > WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic             abort,
  output logic             busy,
  output logic             freeze,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // Architectural state.
  // acc_q is shared by both operations:
  //   MUL: {product high, multiplier / product low}.
  //   DIV: {partial remainder, dividend / quotient}.
  // opnd_q holds the multiplicand (MUL) or the divisor (DIV).
  state_e             state_q,  state_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0]   opnd_q,   opnd_d;
  logic               hi_sel_q, hi_sel_d;   // op[0]: take upper half of acc
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // Iteration datapath.
  logic               accept;
  logic               last_iter;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH:0]     div_rem_full;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic               unused_rem_msb;

  // A new op is taken only from IDLE or DONE, and never alongside abort.
  assign accept    = start & ~abort & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign last_iter = (cnt_q == LAST_CNT);

  // The freeze must be combinational. The stall has to apply in the very cycle
  // the op is accepted, because EXE must not advance past the instruction that
  // owns the unit.
  assign freeze = accept | busy_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

  // One iteration of each algorithm, computed from the current accumulator.
  always_comb begin
    // Multiply: add the multiplicand into the high half when the current
    // multiplier bit is set. Then shift the whole product right by one bit.
    // The carry out of the add becomes the new MSB.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder, and
    // subtract the divisor when it fits. The quotient bit enters at the LSB
    // of the shrinking dividend field. A zero divisor always "fits", so the
    // quotient comes out all ones and the remainder comes out as the dividend.
    div_shift    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge       = (div_shift >= {1'b0, opnd_q});
    div_diff     = div_shift - {1'b0, opnd_q};
    div_rem_full = div_ge ? div_diff : div_shift;
    div_next     = {div_rem_full[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
  end

  // The restored remainder is always below the divisor, so its top bit is 0.
  assign unused_rem_msb = div_rem_full[WIDTH];

  // Next-state and datapath control for the sequencer.
  always_comb begin
    // NOTE: every _d defaults to its current value before the case statement.
    // This way no path through the block leaves a signal unassigned, which
    // would otherwise infer a latch.
    state_d  = state_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_sel_d = hi_sel_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          // The multiplier or the dividend goes into the low half of acc.
          // The other operand is kept in opnd_q.
          state_d  = op[1] ? S_DIV : S_MUL;
          acc_d    = {{WIDTH{1'b0}}, (op[1] ? val1 : val2)};
          opnd_d   = op[1] ? val2 : val1;
          hi_sel_d = op[0];
          cnt_d    = '0;
        end else begin
          // DONE lasts a single cycle.
          state_d = S_IDLE;
        end
      end

      S_MUL, S_DIV: begin
        if (abort) begin
          // The op is killed: no done pulse, and result is left untouched.
          state_d = S_IDLE;
        end else begin
          acc_d = (state_q == S_MUL) ? mul_next : div_next;
          if (last_iter) begin
            state_d  = S_DONE;
            // MULU low / DIVU quotient come from the low half of acc.
            // MULU high / REMU remainder come from the high half.
            result_d = hi_sel_q ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // busy and done are registered copies of the next state's decode.
    busy_d = (state_d == S_MUL) | (state_d == S_DIV);
    done_d = (state_d == S_DONE);
  end

  // All sequencer state is registered here. Reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_sel_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here. All flops then update together
      // from the values computed in the previous cycle, regardless of the
      // order of the statements.
      state_q  <= state_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_sel_q <= hi_sel_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed tests for muldiv_sequencer with hand-computed
// results, latencies and freeze windows.
module tb_muldiv_sequencer;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;
  logic             abort;
  logic             busy;
  logic             freeze;
  logic             done;
  logic [WIDTH-1:0] result;

  int vectors    = 0;
  int miscompares = 0;

  muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .val1   (val1),
    .val2   (val2),
    .abort  (abort),
    .busy   (busy),
    .freeze (freeze),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge, away from
  // the rising edge that the DUT uses.
  //
  // run_op issues one op in cycle t and pulses start for that cycle only.
  // It returns:
  //   lat  - the cycle offset at which done appears (-1 if done never comes).
  //   res  - the result seen in the done cycle.
  //   frz  - the number of cycles with freeze high, from t up to the done cycle.
  //   fdn  - freeze in the done cycle itself.
  task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, output int lat,
                        output logic [WIDTH-1:0] res, output int frz,
                        output logic fdn);
    @(negedge clk);
    op = o; val1 = a; val2 = b; start = 1'b1; abort = 1'b0;
    #1;
    frz = freeze ? 1 : 0;
    lat = -1; res = '0; fdn = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (done) begin
        lat = n; res = result; fdn = freeze;
        break;
      end
      if (freeze) frz++;
    end
  endtask

  // Issues one op and compares it against its expected result, the 33-cycle
  // latency, the 33-cycle freeze window, and freeze=0 in the done cycle.
  task automatic test_op(input string name, input logic [1:0] o,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp);
    int lat, frz;
    logic [WIDTH-1:0] res;
    logic fdn;
    run_op(o, a, b, lat, res, frz, fdn);
    vectors++;
    if (lat !== 33) begin
      miscompares++;
      $display("FAIL %s latency: got %0d expected 33", name, lat);
    end
    vectors++;
    if (res !== exp) begin
      miscompares++;
      $display("FAIL %s result: got %h expected %h", name, res, exp);
    end
    vectors++;
    if (frz !== 33) begin
      miscompares++;
      $display("FAIL %s freeze cycles: got %0d expected 33", name, frz);
    end
    vectors++;
    if (fdn !== 1'b0) begin
      miscompares++;
      $display("FAIL %s freeze in done: got %b expected 0", name, fdn);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; op = 2'b00; val1 = '0; val2 = '0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({busy, done, freeze} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset flags: got busy/done/freeze=%b expected 000",
               {busy, done, freeze});
    end
    vectors++;
    if (result !== '0) begin
      miscompares++;
      $display("FAIL reset result: got %h expected 0", result);
    end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    test_op("mul 7*6",        2'b00, 32'd7,        32'd6,        32'd42);
    test_op("mulhi ff*ff",    2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    test_op("mullo ff*ff",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    test_op("mullo 2^16*2^16", 2'b00, 32'h00010000, 32'h00010000, 32'h00000000);
    test_op("mulhi 2^16*2^16", 2'b01, 32'h00010000, 32'h00010000, 32'h00000001);
  endtask

  task automatic test_div();
    test_op("divu 100/7",    2'b10, 32'd100,      32'd7, 32'd14);
    test_op("remu 100%7",    2'b11, 32'd100,      32'd7, 32'd2);
    test_op("divu ff/1",     2'b10, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF);
    test_op("remu ff%1",     2'b11, 32'hFFFFFFFF, 32'd1, 32'd0);
    test_op("divu 5/9",      2'b10, 32'd5,        32'd9, 32'd0);
    test_op("remu 5%9",      2'b11, 32'd5,        32'd9, 32'd5);
  endtask

  task automatic test_div_by_zero();
    test_op("divu 1234/0", 2'b10, 32'h1234, 32'd0, 32'hFFFFFFFF);
    test_op("remu 1234%0", 2'b11, 32'h1234, 32'd0, 32'h1234);
  endtask

  // A start pulse with different operands while busy must change nothing.
  task automatic test_start_ignored();
    int lat;
    logic [WIDTH-1:0] res;
    @(negedge clk);
    op = 2'b00; val1 = 32'd3; val2 = 32'd5; start = 1'b1; abort = 1'b0;
    lat = -1; res = '0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      start = (n == 5);
      if (n == 5) begin op = 2'b10; val1 = 32'd99; val2 = 32'd1; end
      #1;
      if (done) begin lat = n; res = result; break; end
    end
    vectors++;
    if (lat !== 33) begin
      miscompares++;
      $display("FAIL start-ignored latency: got %0d expected 33", lat);
    end
    vectors++;
    if (res !== 32'd15) begin
      miscompares++;
      $display("FAIL start-ignored result: got %h expected %h", res, 32'd15);
    end
  endtask

  // Abort at t+10: the unit is idle at t+11, done never pulses, and result
  // keeps 15 from the previous op.
  task automatic test_abort();
    bit saw_done = 0;
    @(negedge clk);
    op = 2'b10; val1 = 32'd1000; val2 = 32'd3; start = 1'b1; abort = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start = (n == 5);
      abort = (n == 10);
      #1;
      if (done) saw_done = 1;
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort busy at t+10: got %b expected 1", busy);
    end
    @(negedge clk);
    abort = 1'b0;
    #1;
    vectors++;
    if ({busy, freeze, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort state at t+11: got busy/freeze/done=%b expected 000",
               {busy, freeze, done});
    end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (done) saw_done = 1;
    end
    vectors++;
    if (saw_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort done pulse: got %b expected 0", saw_done);
    end
    vectors++;
    if (result !== 32'd15) begin
      miscompares++;
      $display("FAIL abort result: got %h expected %h", result, 32'd15);
    end
  endtask

  // start together with abort in IDLE is not accepted, and freeze stays low.
  task automatic test_abort_with_start();
    @(negedge clk);
    op = 2'b00; val1 = 32'd2; val2 = 32'd2; start = 1'b1; abort = 1'b1;
    #1;
    vectors++;
    if (freeze !== 1'b0) begin
      miscompares++;
      $display("FAIL abort+start freeze: got %b expected 0", freeze);
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort+start busy: got %b expected 0", busy);
    end
  endtask

  // Asynchronous reset between clock edges clears everything immediately.
  task automatic test_reset_mid_op();
    @(negedge clk);
    op = 2'b00; val1 = 32'd7; val2 = 32'd6; start = 1'b1; abort = 1'b0;
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy, freeze, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL mid-op reset flags: got busy/freeze/done=%b expected 000",
               {busy, freeze, done});
    end
    vectors++;
    if (result !== '0) begin
      miscompares++;
      $display("FAIL mid-op reset result: got %h expected 0", result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // start is held high through DONE. The second op is accepted in the done
  // cycle (freeze=1 there) and completes at t+66.
  task automatic test_back_to_back();
    int d1 = -1, d2 = -1;
    logic [WIDTH-1:0] r1 = '0, r2 = '0;
    logic f1 = 1'b0;
    @(negedge clk);
    op = 2'b00; val1 = 32'd7; val2 = 32'd6; start = 1'b1; abort = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      #1;
      if (done) begin
        if (d1 < 0) begin
          d1 = n; r1 = result; f1 = freeze;
          op = 2'b10; val1 = 32'd100; val2 = 32'd7;
        end else begin
          d2 = n; r2 = result; start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    vectors++;
    if (d1 !== 33 || r1 !== 32'd42) begin
      miscompares++;
      $display("FAIL b2b first: got t+%0d result %h expected t+33 result %h",
               d1, r1, 32'd42);
    end
    vectors++;
    if (f1 !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b freeze in done: got %b expected 1", f1);
    end
    vectors++;
    if (d2 !== 66 || r2 !== 32'd14) begin
      miscompares++;
      $display("FAIL b2b second: got t+%0d result %h expected t+66 result %h",
               d2, r2, 32'd14);
    end
    @(negedge clk);
    #1;
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b idle after: got busy/done=%b expected 00", {busy, done});
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_by_zero();
    test_start_ignored();
    test_abort();
    test_abort_with_start();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
